// File: rtl/avr_tx_arbiter_pkg.sv
// Shared definitions for the AVR transmit arbiter: FSM state encodings and a width helper.
package avr_tx_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int BURST_W = 8;

    // Index/counter width that never collapses to zero bits for tiny parameter values.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/avr_tx_arbiter_picker.sv
// Combinational round-robin picker: selects the first requester at or above ptr, wrapping.
module rr_priority_picker
    import avr_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2_min1(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   index
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scanning from lowest to highest priority lets the last hit (closest to ptr) win.
    always_comb begin
        found    = 1'b0;
        onehot   = '0;
        index    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                found  = 1'b1;
                onehot = NUM_REQ'(1) << cand_idx;
                index  = cand_idx;
            end
        end
    end

endmodule

// File: rtl/avr_tx_arbiter.sv
// Round-robin arbiter sharing the FPGA->AVR serial_tx channel between NUM_REQ requesters,
// with packet locking, a per-grant burst limit and a stall timeout.
module avr_tx_arbiter
    import avr_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int MAX_BURST   = 16,
    parameter int HOLD_CYCLES = 1024
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      new_tx_data,
    input  logic                      tx_busy,
    input  logic                      tx_block,
    output logic                      busy
);

    localparam int IDX_W  = clog2_min1(NUM_REQ);
    localparam int HOLD_W = clog2_min1(HOLD_CYCLES);
    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);
    localparam logic [HOLD_W-1:0]  HOLD_LIMIT  = HOLD_W'(HOLD_CYCLES - 1);

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic               new_tx_data_q, new_tx_data_d;
    logic               last_q, last_d;

    logic               pick_found;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_index;

    logic [DATA_W-1:0]  req_bytes [NUM_REQ];
    logic               owner_valid;
    logic               owner_last;
    logic [DATA_W-1:0]  owner_data;
    logic               send_ok;
    logic               accept;
    logic               do_release;
    logic [IDX_W-1:0]   next_ptr;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .found  (pick_found),
        .onehot (pick_onehot),
        .index  (pick_index)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign owner_valid = req_valid[owner_q];
    assign owner_last  = req_last[owner_q];
    assign owner_data  = req_bytes[owner_q];

    // Flow control only gates the handshake; an issued byte always runs to completion.
    assign send_ok   = (state_q == ST_SEND) && !tx_busy && !tx_block;
    assign accept    = send_ok && owner_valid;
    assign req_ready = send_ok ? grant_q : '0;
    assign next_ptr  = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        burst_cnt_d   = burst_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        tx_data_d     = tx_data_q;
        new_tx_data_d = 1'b0;
        last_d        = last_q;
        do_release    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d     = pick_onehot;
                    owner_d     = pick_index;
                    burst_cnt_d = '0;
                    hold_cnt_d  = '0;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    tx_data_d     = owner_data;
                    new_tx_data_d = 1'b1;
                    last_d        = owner_last;
                    burst_cnt_d   = burst_cnt_q + 1'b1;
                    hold_cnt_d    = '0;
                    state_d       = ST_ISSUE;
                end else if (!owner_valid) begin
                    if (hold_cnt_q == HOLD_LIMIT) begin
                        do_release = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            // serial_tx only raises busy the cycle after the start pulse, so skip one cycle.
            ST_ISSUE: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!tx_busy) begin
                    if (last_q || (burst_cnt_q == BURST_LIMIT)) begin
                        do_release = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_release) begin
            grant_d  = '0;
            rr_ptr_d = next_ptr;
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            burst_cnt_q   <= '0;
            hold_cnt_q    <= '0;
            tx_data_q     <= '0;
            new_tx_data_q <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            burst_cnt_q   <= burst_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            tx_data_q     <= tx_data_d;
            new_tx_data_q <= new_tx_data_d;
            last_q        <= last_d;
        end
    end

    assign grant       = grant_q;
    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_data_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
